// File: rtl/switchbox_cfg_loader_pkg.sv
// Shared constants for the switch-box configuration loader: side-select
// encodings, frame sync byte, routing word width, FSM state type and the
// per-word legality check.
package switchbox_cfg_loader_pkg;

  localparam logic [2:0] SIDE_NONE   = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         WORD_W    = 6;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // A routing word is illegal when its side select is unknown or its port
  // index does not exist on the selected side. SIDE_NONE ignores the index.
  function automatic logic word_bad(input logic [WORD_W-1:0] w,
                                    input int n_tb, input int n_lr);
    logic [2:0] sel;
    logic [2:0] idx;
    logic       bad;
    sel = w[2:0];
    idx = w[5:3];
    bad = 1'b0;
    case (sel)
      SIDE_NONE:               bad = 1'b0;
      SIDE_TOP, SIDE_BOTTOM:   bad = (int'(idx) >= n_tb);
      SIDE_RIGHT, SIDE_LEFT:   bad = (int'(idx) >= n_lr);
      default:                 bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/switchbox_cfg_loader.sv
// Serial configuration loader for a switch box. Hunts for the sync byte,
// shifts one frame of routing words into a shadow image, validates every
// word and commits the whole image atomically.
// Optional feature: define SWITCHBOX_CFG_PARITY_EN to append and check one
// even-parity bit after the last routing word.
// Handshake: a bit transfers on a rising edge where cfg_valid && cfg_ready;
// cfg_ready depends only on the FSM state, never on cfg_valid.
module switchbox_cfg_loader
  import switchbox_cfg_loader_pkg::*;
#(
  parameter int N_TB = 5,
  parameter int N_LR = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_valid,
  input  logic                                 cfg_bit,
  output logic                                 cfg_ready,
  output logic [WORD_W*(2*N_TB+2*N_LR)-1:0]    cfg_image,
  output logic                                 cfg_load,
  output logic                                 cfg_done,
  output logic                                 cfg_err
);

  localparam int S         = 2 * N_TB + 2 * N_LR;
  localparam int DATA_BITS = S * WORD_W;
`ifdef SWITCHBOX_CFG_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 1;
`else
  localparam int FRAME_BITS = DATA_BITS;
`endif
  localparam int CNT_W = 7;
  localparam int IDX_W = $clog2(S);

  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LIMIT = CNT_W'(DATA_BITS);
  localparam logic [2:0]       LAST_POS   = 3'(WORD_W - 1);

  state_t state, state_next;

  // Only seven bits of history are needed: the eighth comes from cfg_bit.
  logic [6:0]              sync_sr;
  logic [7:0]              sync_next;
  logic [WORD_W-2:0]       word_sr;
  logic [WORD_W-1:0]       word_next;
  logic [CNT_W-1:0]        bit_cnt;
  logic [2:0]              bit_pos;
  logic [IDX_W-1:0]        word_idx;
  logic                    bad;
  logic [WORD_W*S-1:0]     shadow;
  logic                    accept;
  logic                    sync_hit;
  logic                    data_bit;
  logic                    frame_ok;
`ifdef SWITCHBOX_CFG_PARITY_EN
  logic                    parity;
`endif

  assign accept    = cfg_valid && cfg_ready;
  assign sync_next = {sync_sr, cfg_bit};
  assign sync_hit  = (sync_next == SYNC_BYTE);
  assign word_next = {word_sr, cfg_bit};
  assign data_bit  = (bit_cnt < DATA_LIMIT);
`ifdef SWITCHBOX_CFG_PARITY_EN
  assign frame_ok  = !bad && !parity;
`else
  assign frame_ok  = !bad;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_SYNC;
    else     state <= state_next;
  end

  // Next-state logic and cfg_ready; the loader only listens in SYNC and LOAD.
  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    case (state)
      ST_SYNC: begin
        cfg_ready = 1'b1;
        if (cfg_valid && sync_hit) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid && bit_cnt == LAST_BIT) state_next = ST_CHECK;
      end
      ST_CHECK:  state_next = frame_ok ? ST_COMMIT : ST_SYNC;
      ST_COMMIT: state_next = ST_SYNC;
      default:   state_next = ST_SYNC;
    endcase
  end

  // Sync hunter: shift accepted bits while idle, clear history once locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_sr <= '0;
    end else if (state == ST_SYNC && accept) begin
      sync_sr <= sync_hit ? 7'd0 : sync_next[6:0];
    end
  end

  // Frame datapath: bit/word counters, shadow image, bad-word and parity tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_sr  <= '0;
      bit_cnt  <= '0;
      bit_pos  <= '0;
      word_idx <= '0;
      bad      <= 1'b0;
      shadow   <= '0;
`ifdef SWITCHBOX_CFG_PARITY_EN
      parity   <= 1'b0;
`endif
    end else if (state == ST_SYNC && accept && sync_hit) begin
      word_sr  <= '0;
      bit_cnt  <= '0;
      bit_pos  <= '0;
      word_idx <= '0;
      bad      <= 1'b0;
`ifdef SWITCHBOX_CFG_PARITY_EN
      parity   <= 1'b0;
`endif
    end else if (state == ST_LOAD && accept) begin
      bit_cnt <= bit_cnt + 1'b1;
`ifdef SWITCHBOX_CFG_PARITY_EN
      parity  <= parity ^ cfg_bit;
`endif
      if (data_bit) begin
        word_sr <= word_next[WORD_W-2:0];
        if (bit_pos == LAST_POS) begin
          bit_pos  <= '0;
          word_idx <= word_idx + 1'b1;
          shadow[word_idx*WORD_W +: WORD_W] <= word_next;
          if (word_bad(word_next, N_TB, N_LR)) bad <= 1'b1;
        end else begin
          bit_pos <= bit_pos + 1'b1;
        end
      end
    end
  end

  // Visible outputs: status cleared on lock, error set in CHECK, image committed in COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_image <= '0;
      cfg_load  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_load <= 1'b0;
      case (state)
        ST_SYNC: begin
          if (accept && sync_hit) begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (!frame_ok) cfg_err <= 1'b1;
        end
        ST_COMMIT: begin
          cfg_image <= shadow;
          cfg_load  <= 1'b1;
          cfg_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Directed bench for switchbox_cfg_loader: a table of single-frame routing
// images with hand-derived accept/reject outcomes, followed by hand-written
// sequences for sync noise, valid gaps, mid-frame reset and parity.
module tb_switchbox_cfg_loader;

  localparam int N_TB = 5;
  localparam int N_LR = 4;
  localparam int S    = 2 * N_TB + 2 * N_LR;
  localparam int IW   = 6 * S;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_bit;
  logic          cfg_ready;
  logic [IW-1:0] cfg_image;
  logic          cfg_load;
  logic          cfg_done;
  logic          cfg_err;

  int n_vec  = 0;
  int n_miss = 0;

  logic [IW-1:0] exp_image;

  typedef struct {
    string         name;
    logic [IW-1:0] img;
    logic          ok;
  } vec_t;

  vec_t vecs[12];

  switchbox_cfg_loader #(.N_TB(N_TB), .N_LR(N_LR)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_image (cfg_image),
    .cfg_load  (cfg_load),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] slot_word(input int k, input logic [5:0] w);
    logic [IW-1:0] r;
    r = '0;
    r[k*6 +: 6] = w;
    return r;
  endfunction

  task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one bit, optionally preceded by idle cycles, and return after the
  // edge that accepted it.
  task automatic send_bit(input logic b, input logic gaps);
    int g;
    int guard;
    if (gaps) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        cfg_valid = 1'b0;
        cfg_bit   = 1'($urandom_range(0, 1));
        tick();
      end
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    guard     = 0;
    while (!cfg_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check("ready_timeout", {{(IW-1){1'b0}}, cfg_ready}, {{(IW-1){1'b0}}, 1'b1});
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_data(input logic [IW-1:0] img, input int nbits, input logic gaps);
    logic [7:0] sb;
    sb = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(sb[i], gaps);
    for (int k = 0; k < S; k++) begin
      for (int b = 5; b >= 0; b--) begin
        if (k * 6 + (5 - b) < nbits) send_bit(img[k*6 + b], gaps);
      end
    end
  endtask

  task automatic send_frame(input logic [IW-1:0] img, input logic gaps, input logic flip_par);
    send_data(img, IW, gaps);
`ifdef SWITCHBOX_CFG_PARITY_EN
    send_bit((^img) ^ flip_par, gaps);
`else
    if (flip_par) $display("note: parity flip ignored in this build");
`endif
  endtask

  // Cycle-exact outcome checks starting one step after the last accepted bit.
  task automatic post_check(input string name, input logic ok, input logic [IW-1:0] img);
    check({name, "_ready_check"}, IW'(cfg_ready), IW'(0));
    check({name, "_img_t0"}, cfg_image, exp_image);
    check({name, "_load_t0"}, IW'(cfg_load), IW'(0));
    tick();
    check({name, "_img_t1"}, cfg_image, exp_image);
    check({name, "_load_t1"}, IW'(cfg_load), IW'(0));
    check({name, "_err_t1"}, IW'(cfg_err), IW'(!ok));
    check({name, "_ready_t1"}, IW'(cfg_ready), IW'(!ok));
    tick();
    if (ok) exp_image = img;
    check({name, "_img_t2"}, cfg_image, exp_image);
    check({name, "_load_t2"}, IW'(cfg_load), IW'(ok));
    check({name, "_done_t2"}, IW'(cfg_done), IW'(ok));
    check({name, "_err_t2"}, IW'(cfg_err), IW'(!ok));
    tick();
    check({name, "_load_t3"}, IW'(cfg_load), IW'(0));
    check({name, "_img_t3"}, cfg_image, exp_image);
  endtask

  initial begin
    vecs[0]  = '{"top0_right2", slot_word(0, 6'b010_010), 1'b1};
    vecs[1]  = '{"left3_top5", slot_word(13, 6'b101_001), 1'b0};
    vecs[2]  = '{"sel5", slot_word(3, 6'b000_101), 1'b0};
    vecs[3]  = '{"top_idx4", slot_word(2, 6'b100_001), 1'b1};
    vecs[4]  = '{"right_idx4", slot_word(15, 6'b100_010), 1'b0};
    vecs[5]  = '{"right_idx3", slot_word(17, 6'b011_010), 1'b1};
    vecs[6]  = '{"left_idx4", slot_word(10, 6'b100_100), 1'b0};
    vecs[7]  = '{"bottom_idx5", slot_word(9, 6'b101_011), 1'b0};
    vecs[8]  = '{"none_idx7", slot_word(7, 6'b111_000), 1'b1};
    vecs[9]  = '{"sel7", slot_word(16, 6'b000_111), 1'b0};
    vecs[10] = '{"a5_in_data", slot_word(0, 6'b010_100) | slot_word(1, 6'b101_000), 1'b1};
    vecs[11] = '{"multi", slot_word(4, 6'b011_100) | slot_word(11, 6'b100_011)
                          | slot_word(14, 6'b000_011), 1'b1};

    // reset
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    exp_image = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_ready", IW'(cfg_ready), IW'(1));
    check("rst_image", cfg_image, '0);
    check("rst_load", IW'(cfg_load), IW'(0));
    check("rst_done", IW'(cfg_done), IW'(0));
    check("rst_err", IW'(cfg_err), IW'(0));

    // table-driven frames
    for (int i = 0; i < 12; i++) begin
      send_frame(vecs[i].img, 1'b0, 1'b0);
      post_check(vecs[i].name, vecs[i].ok, vecs[i].img);
      repeat (2) tick();
    end

    // noise ahead of the sync byte
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("noise_no_lock_err", IW'(cfg_err), IW'(0));
    send_frame(vecs[0].img, 1'b0, 1'b0);
    post_check("noise", 1'b1, vecs[0].img);

    // same frame with random valid gaps, same latency after the last bit
    send_frame(vecs[0].img, 1'b1, 1'b0);
    post_check("gaps", 1'b1, vecs[0].img);

    // reset after 50 data bits discards the frame
    send_data(vecs[11].img, 50, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_image = '0;
    tick();
    check("midrst_image", cfg_image, '0);
    check("midrst_done", IW'(cfg_done), IW'(0));
    check("midrst_ready", IW'(cfg_ready), IW'(1));
    send_frame(vecs[3].img, 1'b1, 1'b0);
    post_check("after_rst", 1'b1, vecs[3].img);

`ifdef SWITCHBOX_CFG_PARITY_EN
    send_frame(vecs[11].img, 1'b0, 1'b1);
    post_check("parity_flip", 1'b0, vecs[11].img);
    send_frame(vecs[11].img, 1'b0, 1'b0);
    post_check("parity_ok", 1'b1, vecs[11].img);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/switchbox_cfg_loader.md
SWITCHBOX_CFG_LOADER -- requirements
Module: switchbox_cfg_loader

Interface
REQ-001 Parameter N_TB, default 5: number of top and of bottom switch-box ports.
REQ-002 Parameter N_LR, default 4: number of left and of right switch-box ports.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cfg_valid  input  1  serial config bit present on cfg_bit.
REQ-006 cfg_bit  input  1  serial config stream, MSB of each field first.
REQ-007 cfg_ready  output  1  loader accepts a bit; a transfer occurs when cfg_valid && cfg_ready.
REQ-008 cfg_image  output  6*(2*N_TB+2*N_LR)  routing image; slot k occupies bits [6k+5:6k], [2:0]=side select (0 none, 1 top, 2 right, 3 bottom, 4 left), [5:3]=port index.
REQ-009 cfg_load  output  1  one-cycle pulse on the cycle cfg_image changes.
REQ-010 cfg_done  output  1  level: last frame committed successfully.
REQ-011 cfg_err  output  1  level: last frame rejected.

Function
REQ-012 Frame = sync byte 8'hA5, then S=2*N_TB+2*N_LR 6-bit words in slot order top[0..N_TB-1], bottom[0..N_TB-1], left[0..N_LR-1], right[0..N_LR-1] (108 bits at defaults).
REQ-013 FSM states SYNC, LOAD, CHECK, COMMIT; reset enters SYNC.
REQ-014 SYNC: cfg_ready=1; each accepted bit shifts into an 8-bit register; on the accepted bit that makes it 8'hA5, go to LOAD and clear cfg_done and cfg_err.
REQ-015 LOAD: cfg_ready=1; accepted bits shift into a shadow register; a 7-bit bit counter advances only on accepted bits; cycles with cfg_valid=0 stall without side effects.
REQ-016 On each completed word, mark bad if select>4, or select in {1,3} with index>=N_TB, or select in {2,4} with index>=N_LR; select=0 ignores index.
REQ-017 After the final frame bit is accepted, go to CHECK next cycle; CHECK and COMMIT drive cfg_ready=0.
REQ-018 CHECK (one cycle): if no bad word (and parity ok, REQ-024), go to COMMIT; else set cfg_err=1, leave cfg_image unchanged, return to SYNC.
REQ-019 COMMIT (one cycle): cfg_image <= shadow, cfg_load=1, cfg_done=1, return to SYNC.
REQ-020 Latency: last accepted bit at cycle t -> cfg_image/cfg_load/cfg_done updated at the end of cycle t+2.
REQ-021 cfg_image is updated atomically; partial frames are never visible.
REQ-022 A second 8'hA5 pattern inside LOAD is treated as data, not resync.

Reset
REQ-023 On rst: state=SYNC, cfg_image=0 (all ports undriven), cfg_load=0, cfg_done=0, cfg_err=0, sync register, shadow, bit counter and bad flag cleared; cfg_ready=1 from the first cycle after rst deasserts; reset mid-frame discards the frame.

Configuration
REQ-024 Macro SWITCHBOX_CFG_PARITY_EN defined: frame carries one extra bit after the last word; even parity over all data bits plus that bit must be 0, else CHECK rejects (REQ-018); undefined: no parity bit, the frame ends after the last word, and no parity check is made.

Structure
REQ-025 Shared package holds the side-select constants (NONE=0, TOP=1, RIGHT=2, BOTTOM=3, LEFT=4), the sync constant 8'hA5 and the word width 6.
REQ-026 No sub-module; single module.

Verification
REQ-027 Reset, then valid frame with top[0]=6'b010_010 (right port 2), all other words 0 -> cfg_image[5:0]=6'b010010, all other bits 0, one cfg_load pulse, cfg_done=1, cfg_err=0.
REQ-028 Frame with left[3]=6'b101_001 (top index 5) -> cfg_err=1, cfg_image keeps its previous value, no cfg_load.
REQ-029 Noise bits 1,1,0 before A5, then valid frame -> frame accepted and committed; then a valid frame with random cfg_valid gaps -> identical result, with the same latency after the last accepted bit.
REQ-030 rst asserted after 50 data bits, then a full valid frame -> cfg_image=0 until the new commit, then equals the new frame.
REQ-031 With SWITCHBOX_CFG_PARITY_EN: correct parity -> commit; flipped parity bit -> cfg_err=1. Without the macro: frame length 8+108 bits commits.
